rsa_block_sequencer: RTL

RSA_BLOCK_SEQUENCER -- requirements
Module: rsa_block_sequencer

---
 rtl/rsa_pkg.sv | 16 +
 rtl/byte_serializer.sv | 71 +++++++
 rtl/rsa_block_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA block sequencer: FSM state encoding and block geometry.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_PACK,
    ST_CHECK,
    ST_LAUNCH,
    ST_WAIT,
    ST_EMIT
  } seq_state_t;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Loads one WIDTH-bit block and presents it MSB byte first on a valid/ready port.
module byte_serializer #(
  parameter int WIDTH = 16,
  parameter int BYTES = WIDTH / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  output logic [7:0]       byte_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o,
  output logic             done_o
);

  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             fire;

  assign fire = valid_q && ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_i) begin
      data_d  = data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
      last_d  = last_i;
    end else if (fire) begin
      if (cnt_q == LAST_IDX) begin
        data_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        data_d = {data_q[WIDTH-9:0], 8'h00};
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  assign byte_o  = data_q[WIDTH-1 -: 8];
  assign valid_o = valid_q;
  assign last_o  = valid_q && last_q && (cnt_q == LAST_IDX);
  assign done_o  = fire && (cnt_q == LAST_IDX);

endmodule

// File: rtl/rsa_block_sequencer.sv
// Packs plaintext bytes into blocks, hands each block to an external exponent_modulus
// engine, and serialises the result back out as bytes. One block in flight at a time.
module rsa_block_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BYTES = bytes_of(WIDTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid_in,
  output logic             byte_ready_out,
  input  logic             last_in,
  input  logic [WIDTH-1:0] key_exponent_in,
  input  logic [WIDTH-1:0] key_modulus_in,
  output logic             exp_ready_out,
  output logic [WIDTH-1:0] exp_value_out,
  input  logic             exp_busy_in,
  input  logic             exp_valid_in,
  input  logic [WIDTH-1:0] exp_result_in,
  output logic [7:0]       byte_out,
  output logic             byte_valid_out,
  input  logic             byte_ready_in,
  output logic             last_out,
  output logic             error_out
);

  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] block_q, block_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             in_fire, too_big, ser_load, ser_done;
  logic             unused_key;

  // The exponent is consumed by the external engine, not here.
  assign unused_key = ^key_exponent_in;

  assign in_fire = (state_q == ST_PACK) && byte_valid_in;
  assign too_big = (block_q >= key_modulus_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_PACK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PACK:   if (in_fire && (last_in || cnt_q == LAST_IDX)) state_d = ST_CHECK;
      ST_CHECK:  state_d = too_big ? ST_PACK : ST_LAUNCH;
      ST_LAUNCH: if (!exp_busy_in) state_d = ST_WAIT;
      ST_WAIT:   if (exp_valid_in) state_d = ST_EMIT;
      ST_EMIT:   if (ser_done) state_d = ST_PACK;
      default:   state_d = ST_PACK;
    endcase
  end

  always_comb begin
    byte_ready_out = (state_q == ST_PACK) && !rst_in;
    error_out      = (state_q == ST_CHECK) && too_big;
    exp_ready_out  = (state_q == ST_LAUNCH) && !exp_busy_in;
    ser_load       = (state_q == ST_WAIT) && exp_valid_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      block_q <= '0;
      value_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      block_q <= block_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Shifting in from the LSB end leaves a short final block right-aligned.
  always_comb begin
    block_d = block_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (in_fire) begin
      block_d = {block_q[WIDTH-9:0], byte_in};
      cnt_d   = cnt_q + CW'(1);
      last_d  = last_in;
    end else if (state_q == ST_CHECK) begin
      block_d = '0;
      cnt_d   = '0;
      if (!too_big) value_d = block_q;
    end
  end

  assign exp_value_out = value_q;

  byte_serializer #(
    .WIDTH (WIDTH),
    .BYTES (BYTES)
  ) u_ser (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .load_i  (ser_load),
    .data_i  (exp_result_in),
    .last_i  (last_q),
    .byte_o  (byte_out),
    .valid_o (byte_valid_out),
    .ready_i (byte_ready_in),
    .last_o  (last_out),
    .done_o  (ser_done)
  );

endmodule
